// File: rtl/shared_divider.sv
// Iterative radix-2 restoring divider shared by two clients, one quotient bit per clock.
// Optional rounding stage enabled by defining SHARED_DIVIDER_ROUND_EN.
module shared_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             select,
  input  logic [WIDTH-1:0] dividend_a,
  input  logic [WIDTH-1:0] divisor_a,
  input  logic [WIDTH-1:0] dividend_b,
  input  logic [WIDTH-1:0] divisor_b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             ready,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] shreg;      // dividend bits shift out the top, quotient bits shift in
  logic [WIDTH:0]   prem;
  logic [CNT_W-1:0] count;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   next_prem;
  logic [WIDTH-1:0] next_q;
  logic             qbit;
  logic             dz;

  // One restoring step; a zero divisor naturally yields all-ones and remainder = dividend.
  always_comb begin
    shifted   = (WIDTH+1)'((prem << 1) | {{WIDTH{1'b0}}, shreg[WIDTH-1]});
    qbit      = (shifted >= {1'b0, divisor_q});
    next_prem = qbit ? (shifted - {1'b0, divisor_q}) : shifted;
    next_q    = {shreg[WIDTH-2:0], qbit};
    dz        = (divisor_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      divisor_q   <= '0;
      shreg       <= '0;
      prem        <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      ready       <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            divisor_q   <= select ? divisor_b : divisor_a;
            shreg       <= select ? dividend_b : dividend_a;
            prem        <= '0;
            count       <= CNT_W'(WIDTH - 1);
            ready       <= 1'b0;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= CALC;
          end
        end
        CALC: begin
          prem  <= next_prem;
          shreg <= next_q;
          if (count != '0) begin
            count <= count - 1'b1;
          end else begin
`ifdef SHARED_DIVIDER_ROUND_EN
            state <= ROUND;
`else
            quotient    <= next_q;
            remainder   <= next_prem[WIDTH-1:0];
            div_by_zero <= dz;
            busy        <= 1'b0;
            ready       <= 1'b1;
            state       <= IDLE;
`endif
          end
        end
`ifdef SHARED_DIVIDER_ROUND_EN
        ROUND: begin
          // Round half up; remainder is reported unrounded and all-ones saturates.
          if (!dz && ({prem[WIDTH-1:0], 1'b0} >= {1'b0, divisor_q}) && (shreg != '1))
            quotient <= shreg + 1'b1;
          else
            quotient <= shreg;
          remainder   <= prem[WIDTH-1:0];
          div_by_zero <= dz;
          busy        <= 1'b0;
          ready       <= 1'b1;
          state       <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_divider.sv
// Self-checking bench for shared_divider: directed cases plus randomized operands
// against an arithmetic reference model.
module tb_shared_divider;

  localparam int unsigned WIDTH = 16;
`ifdef SHARED_DIVIDER_ROUND_EN
  localparam int LAT = WIDTH + 2;
  localparam bit RND = 1'b1;
`else
  localparam int LAT = WIDTH + 1;
  localparam bit RND = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, start, select;
  logic [WIDTH-1:0] dividend_a, divisor_a, dividend_b, divisor_b;
  logic [WIDTH-1:0] quotient, remainder;
  logic             busy, ready, div_by_zero;

  int checks = 0;
  int errors = 0;

  shared_divider #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .select(select),
    .dividend_a(dividend_a), .divisor_a(divisor_a),
    .dividend_b(dividend_b), .divisor_b(divisor_b),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .ready(ready), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic dz);
    longint unsigned qq, rr;
    if (b == 16'd0) begin
      q = 16'hFFFF; r = a; dz = 1'b1;
    end else begin
      qq = longint'(a) / longint'(b);
      rr = longint'(a) % longint'(b);
      if (RND && (2 * rr >= longint'(b)) && (qq < 65535)) qq++;
      q = 16'(qq); r = 16'(rr); dz = 1'b0;
    end
  endfunction

  // Accept one request; afterwards scramble every operand port and select.
  task automatic start_req(input logic sel, input logic [15:0] a, input logic [15:0] b);
    select = sel;
    if (sel) begin
      dividend_b = a; divisor_b = b;
      dividend_a = 16'($urandom); divisor_a = 16'($urandom);
    end else begin
      dividend_a = a; divisor_a = b;
      dividend_b = 16'($urandom); divisor_b = 16'($urandom);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    select = 1'($urandom);
    dividend_a = 16'($urandom); divisor_a = 16'($urandom);
    dividend_b = 16'($urandom); divisor_b = 16'($urandom);
  endtask

  task automatic wait_done(output int cyc, output int bcyc);
    cyc = 0; bcyc = 0;
    while (ready !== 1'b1 && cyc < 64) begin
      if (busy === 1'b1) bcyc++;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; select = 1'b0;
    dividend_a = '0; divisor_a = '0; dividend_b = '0; divisor_b = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({quotient, remainder, busy, ready, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_state got q=%0d r=%0d busy=%b ready=%b dz=%b exp all zero",
               quotient, remainder, busy, ready, div_by_zero);
    end
  endtask

  task automatic test_directed();
    logic [15:0] ta [4] = '{16'd1000, 16'd500, 16'd65535, 16'd3};
    logic [15:0] tb [4] = '{16'd7, 16'd0, 16'd1, 16'd65535};
    logic [15:0] eq, er;
    logic        edz;
    int cyc, bcyc;
    for (int i = 0; i < 4; i++) begin
      start_req(1'b0, ta[i], tb[i]);
      wait_done(cyc, bcyc);
      model(ta[i], tb[i], eq, er, edz);
      checks++;
      if (cyc != LAT - 1 || bcyc != LAT - 1) begin
        errors++;
        $display("FAIL dir_latency[%0d] got wait=%0d busy_cycles=%0d exp %0d", i, cyc, bcyc, LAT - 1);
      end
      checks++;
      if (quotient !== eq || remainder !== er || div_by_zero !== edz || busy !== 1'b0) begin
        errors++;
        $display("FAIL dir_result[%0d] %0d/%0d got q=%0d r=%0d dz=%b busy=%b exp q=%0d r=%0d dz=%b busy=0",
                 i, ta[i], tb[i], quotient, remainder, div_by_zero, busy, eq, er, edz);
      end
    end
    // Independent constants for the headline case.
    checks++;
    start_req(1'b0, 16'd1000, 16'd7);
    wait_done(cyc, bcyc);
    if (quotient !== (RND ? 16'd143 : 16'd142) || remainder !== 16'd6) begin
      errors++;
      $display("FAIL dir_1000_7 got q=%0d r=%0d exp q=%0d r=6", quotient, remainder, RND ? 143 : 142);
    end
  endtask

  task automatic test_select_b();
    int cyc, bcyc;
    select = 1'b1;
    dividend_a = 16'd5; divisor_a = 16'd5;
    dividend_b = 16'd100; divisor_b = 16'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    dividend_b = 16'd9; divisor_b = 16'd3;
    dividend_a = 16'd0; divisor_a = 16'd0;
    select = 1'b0;
    wait_done(cyc, bcyc);
    checks++;
    if (quotient !== 16'd10 || remainder !== 16'd0 || div_by_zero !== 1'b0 || cyc != LAT - 4) begin
      errors++;
      $display("FAIL select_b got q=%0d r=%0d dz=%b wait=%0d exp q=10 r=0 dz=0 wait=%0d",
               quotient, remainder, div_by_zero, cyc, LAT - 4);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] eq, er;
    logic        edz;
    int cyc, bcyc;
    start_req(1'b0, 16'd1000, 16'd7);
    tick(); tick(); tick(); tick();
    select = 1'b1;
    dividend_a = 16'd9; divisor_a = 16'd3; dividend_b = 16'd9; divisor_b = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc, bcyc);
    model(16'd1000, 16'd7, eq, er, edz);
    checks++;
    if (quotient !== eq || remainder !== er || cyc != LAT - 6) begin
      errors++;
      $display("FAIL ignored_start got q=%0d r=%0d wait=%0d exp q=%0d r=%0d wait=%0d",
               quotient, remainder, cyc, eq, er, LAT - 6);
    end
    // Start in the first ready cycle must be accepted.
    start_req(1'b0, 16'd9, 16'd3);
    checks++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got ready=%b busy=%b exp ready=0 busy=1", ready, busy);
    end
    wait_done(cyc, bcyc);
    checks++;
    if (quotient !== 16'd3 || remainder !== 16'd0 || cyc != LAT - 1) begin
      errors++;
      $display("FAIL b2b_result got q=%0d r=%0d wait=%0d exp q=3 r=0 wait=%0d", quotient, remainder, cyc, LAT - 1);
    end
  endtask

  task automatic test_reset_mid();
    int rdy_seen, busy_seen;
    start_req(1'b0, 16'd1000, 16'd7);
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0 || quotient !== 16'd0 || remainder !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b ready=%b q=%0d r=%0d exp all zero", busy, ready, quotient, remainder);
    end
    rdy_seen = 0; busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready === 1'b1) rdy_seen++;
      if (busy === 1'b1) busy_seen++;
      tick();
    end
    checks++;
    if (rdy_seen != 0 || busy_seen != 0) begin
      errors++;
      $display("FAIL reset_drop got ready_cycles=%0d busy_cycles=%0d exp 0 0", rdy_seen, busy_seen);
    end
    // Reset and start together: reset wins.
    dividend_a = 16'd50; divisor_a = 16'd5; select = 1'b0;
    start = 1'b1; rst = 1'b1;
    tick();
    start = 1'b0; rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_vs_start got busy=%b ready=%b exp 0 0", busy, ready);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, eq, er;
    logic        edz, sel;
    int cyc, bcyc;
    for (int i = 0; i < 24; i++) begin
      sel = 1'($urandom);
      a = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        2:       b = a + 16'($urandom_range(0, 3));
        default: b = 16'($urandom);
      endcase
      start_req(sel, a, b);
      wait_done(cyc, bcyc);
      model(a, b, eq, er, edz);
      checks++;
      if (quotient !== eq || remainder !== er || div_by_zero !== edz || cyc != LAT - 1 || bcyc != LAT - 1) begin
        errors++;
        $display("FAIL rand[%0d] sel=%b %0d/%0d got q=%0d r=%0d dz=%b wait=%0d busy=%0d exp q=%0d r=%0d dz=%b wait=%0d",
                 i, sel, a, b, quotient, remainder, div_by_zero, cyc, bcyc, eq, er, edz, LAT - 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_select_b();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
